// File: rtl/ipv4_tx.sv
// ipv4_tx: IPv4 transmit framer between the UDP TX path and the MAC TX path.
//
// When a packet starts, the block emits a 20-byte IPv4 header with no options
// as ten 16-bit words. The header carries fixed fields, the total length, an
// incrementing identification and the header checksum. The block then passes
// the transport payload through to the MAC and counts bytes against the
// announced length. It does no fragmentation. A payload that is too long for
// one datagram is consumed and dropped. An underrun aborts the frame toward
// the MAC.
//
// Ports:
//   clk        in   clock
//   nreset     in   synchronous active-low reset
//   cancel_i   in   transport abort; returns the block to IDLE
//   valid_i    in   transport word valid
//   data_i     in   payload word, byte 2k on [7:0], byte 2k+1 on [15:8]
//   len_i      in   valid bytes in data_i (1 or 2; 1 only on the last word)
//   pkt_len_i  in   payload byte count, sampled on the start cycle
//   ready_o    out  payload word consumed when valid_i & ready_o
//   valid_o    out  MAC word valid
//   data_o     out  MAC word, same byte order as data_i
//   len_o      out  valid bytes in data_o
//   cancel_o   out  one-cycle abort to the MAC
//   err_o      out  one-cycle error pulse (underrun or oversize)
//
// Only DATA_W = 16 is supported.

module ipv4_tx #(
    parameter int                DATA_W   = 16,
    parameter int                LEN_W    = $clog2(DATA_W/8) + 1,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] SRC_ADDR = {8'd206, 8'd200, 8'd127, 8'd128},
    parameter logic [ADDR_W-1:0] DST_ADDR = {8'd206, 8'd200, 8'd127, 8'd128},
    parameter logic [7:0]        PROTOCOL = 8'd17,
    parameter logic [7:0]        TTL      = 8'd64,
    parameter logic [7:0]        TOS      = 8'd0,
    parameter logic [2:0]        FLAGS    = 3'b010
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cancel_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [15:0]       pkt_len_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              cancel_o,
    output logic              err_o
);

    // Largest payload that still fits in a 65535-byte datagram after the
    // 20-byte header.
    localparam logic [15:0] MAX_PAYLOAD = 16'd65515;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_HEAD = 4'b0010,
        S_DATA = 4'b0100,
        S_DROP = 4'b1000
    } state_t;

    // One's-complement 16-bit add with end-around carry. The carry can be
    // added back in 16 bits: the largest sum, 0xFFFF + 0xFFFF, folds to 0xFFFF.
    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'b0, s[16]};
    endfunction

    // The address words never change, so their sum is folded at elaboration.
    localparam logic [15:0] ADDR_SUM =
        csum_add(csum_add(SRC_ADDR[31:16], SRC_ADDR[15:0]),
                 csum_add(DST_ADDR[31:16], DST_ADDR[15:0]));

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_hcnt;
    logic [15:0] r_acc;
    logic [15:0] r_id_q;
    logic [15:0] r_pkt_len_q;
    logic [15:0] r_bcnt;

    logic        w_start;
    logic        w_accept;
    logic        w_id_inc;
    logic        w_last;
    logic [16:0] w_bcnt_sum;
    logic [15:0] w_tot_len;
    logic [15:0] w_csum;
    logic [15:0] w_hdr_be;

    assign w_tot_len  = r_pkt_len_q + 16'd20;
    assign w_csum     = ~csum_add(r_acc, ADDR_SUM);
    // 17-bit sum so that a 65535-byte count cannot wrap past the limit.
    assign w_bcnt_sum = {1'b0, r_bcnt} + 17'(len_i);
    assign w_last     = (w_bcnt_sum >= {1'b0, r_pkt_len_q});

    // Header word hcnt in network (big-endian) order. It is byte-swapped onto
    // data_o, so the first byte on the wire sits in [7:0].
    always_comb begin
        w_hdr_be = '0;
        case (r_hcnt)
            4'd0: w_hdr_be = {8'h45, TOS};
            4'd1: w_hdr_be = w_tot_len;
            4'd2: w_hdr_be = r_id_q;
            4'd3: w_hdr_be = {FLAGS, 13'b0};
            4'd4: w_hdr_be = {TTL, PROTOCOL};
            4'd5: w_hdr_be = w_csum;
            4'd6: w_hdr_be = SRC_ADDR[31:16];
            4'd7: w_hdr_be = SRC_ADDR[15:0];
            4'd8: w_hdr_be = DST_ADDR[31:16];
            4'd9: w_hdr_be = DST_ADDR[15:0];
            default: w_hdr_be = '0;
        endcase
    end

    // NOTE: every output and the next state get a default before the case;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        w_id_inc    = 1'b0;
        ready_o     = 1'b0;
        valid_o     = 1'b0;
        data_o      = '0;
        len_o       = '0;
        cancel_o    = 1'b0;
        err_o       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (valid_i && !cancel_i) begin
                    w_start = 1'b1;
                    if (pkt_len_i > MAX_PAYLOAD) begin
                        err_o       = 1'b1;
                        w_state_nxt = S_DROP;
                    end else begin
                        w_state_nxt = S_HEAD;
                    end
                end
            end

            S_HEAD: begin
                valid_o = 1'b1;
                len_o   = LEN_W'(2);
                data_o  = {w_hdr_be[7:0], w_hdr_be[15:8]};
                if (cancel_i) begin
                    cancel_o    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_hcnt == 4'd9) begin
                    w_id_inc    = 1'b1;
                    w_state_nxt = (r_pkt_len_q != 16'd0) ? S_DATA : S_IDLE;
                end
            end

            S_DATA: begin
                ready_o = 1'b1;
                valid_o = valid_i;
                if (valid_i) begin
                    data_o = data_i;
                    len_o  = len_i;
                end
                if (cancel_i) begin
                    cancel_o    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (!valid_i) begin
                    // The transport ran dry mid-frame, so the MAC frame is aborted.
                    cancel_o    = 1'b1;
                    err_o       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_accept = 1'b1;
                    if (w_last) w_state_nxt = S_IDLE;
                end
            end

            S_DROP: begin
                ready_o = 1'b1;
                if (cancel_i) begin
                    w_state_nxt = S_IDLE;
                end else if (!valid_i) begin
                    // Nothing reached the MAC, so only the error is reported.
                    err_o       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_accept = 1'b1;
                    if (w_last) w_state_nxt = S_IDLE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value no matter how the statements are ordered.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            // NOTE: the few datapath registers are also reset; this is cheap
            // and keeps simulation free of X after reset.
            r_state     <= S_IDLE;
            r_hcnt      <= '0;
            r_acc       <= '0;
            r_id_q      <= '0;
            r_pkt_len_q <= '0;
            r_bcnt      <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_start) begin
                r_pkt_len_q <= pkt_len_i;
                r_hcnt      <= '0;
                r_acc       <= '0;
                r_bcnt      <= '0;
            end

            if (r_state == S_HEAD) begin
                r_hcnt <= r_hcnt + 4'd1;
                // Words 0..4 are all the variable words before the checksum
                // slot. The checksum field counts as zero and the addresses
                // come from ADDR_SUM.
                if (r_hcnt <= 4'd4) r_acc <= csum_add(r_acc, w_hdr_be);
            end

            if (w_accept) r_bcnt <= w_bcnt_sum[15:0];

            if (w_id_inc) r_id_q <= r_id_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_ipv4_tx.sv
// tb_ipv4_tx: directed, self-checking testbench for ipv4_tx.
//
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// later, which is well away from the rising edge. All header words and
// checksums below were computed by hand for the default parameters.

module tb_ipv4_tx;

    logic        clk = 1'b0;
    logic        nreset;
    logic        cancel_i;
    logic        valid_i;
    logic [15:0] data_i;
    logic [1:0]  len_i;
    logic [15:0] pkt_len_i;
    logic        ready_o;
    logic        valid_o;
    logic [15:0] data_o;
    logic [1:0]  len_o;
    logic        cancel_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_nordy  = 0;
    int n_vld    = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    ipv4_tx dut (
        .clk       (clk),
        .nreset    (nreset),
        .cancel_i  (cancel_i),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .len_i     (len_i),
        .pkt_len_i (pkt_len_i),
        .ready_o   (ready_o),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .len_o     (len_o),
        .cancel_o  (cancel_o),
        .err_o     (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pay_word(input logic [7:0] base, input int w);
        return {base + 8'(2*w + 1), base + 8'(2*w)};
    endfunction

    // Sends one packet and checks every output cycle by cycle.
    // cancel_hcnt >= 0 raises cancel_i while that header word is on the bus.
    // abort_word >= 0 stops the payload at that word index. With abort_rst
    // clear, valid_i drops there (an underrun). With abort_rst set, nreset is
    // asserted alongside that word.
    // chain leaves out the idle cycle at the end, so the next packet starts
    // on the first IDLE cycle.
    task automatic run_pkt(input string nm, input logic [15:0] nbytes,
                           input logic [15:0] exp_id, input logic [15:0] exp_csum,
                           input logic [7:0] base, input int cancel_hcnt,
                           input int abort_word, input bit abort_rst, input bit chain);
        logic [15:0] hdr [10];
        logic [15:0] tot;
        int          nwords;
        tot     = nbytes + 16'd20;
        hdr[0]  = 16'h0045;
        hdr[1]  = {tot[7:0], tot[15:8]};
        hdr[2]  = {exp_id[7:0], exp_id[15:8]};
        hdr[3]  = 16'h0040;
        hdr[4]  = 16'h1140;
        hdr[5]  = {exp_csum[7:0], exp_csum[15:8]};
        hdr[6]  = 16'hC8CE;
        hdr[7]  = 16'h807F;
        hdr[8]  = 16'hC8CE;
        hdr[9]  = 16'h807F;
        nwords  = (int'(nbytes) + 1) / 2;

        // Start cycle: the block is in IDLE and the first word is held.
        @(negedge clk);
        valid_i   = 1'b1;
        data_i    = pay_word(base, 0);
        len_i     = (nwords == 1 && nbytes[0]) ? 2'd1 : 2'd2;
        pkt_len_i = nbytes;
        #1;
        check($sformatf("%s/start_ready", nm), 32'(ready_o), 32'd0);
        check($sformatf("%s/start_valid", nm), 32'(valid_o), 32'd0);
        check($sformatf("%s/start_err", nm), 32'(err_o), 32'd0);

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (nwords == 0) valid_i = 1'b0;
            cancel_i = (k == cancel_hcnt);
            #1;
            check($sformatf("%s/hdr%0d", nm, k), 32'(data_o), 32'(hdr[k]));
            check($sformatf("%s/hdr%0d_valid", nm, k), 32'(valid_o), 32'd1);
            check($sformatf("%s/hdr%0d_len", nm, k), 32'(len_o), 32'd2);
            check($sformatf("%s/hdr%0d_ready", nm, k), 32'(ready_o), 32'd0);
            if (k == cancel_hcnt) begin
                check($sformatf("%s/cancel_o", nm), 32'(cancel_o), 32'd1);
                @(negedge clk);
                cancel_i = 1'b0;
                valid_i  = 1'b0;
                #1;
                check($sformatf("%s/post_cancel_valid", nm), 32'(valid_o), 32'd0);
                check($sformatf("%s/post_cancel_ready", nm), 32'(ready_o), 32'd0);
                check($sformatf("%s/post_cancel_cancel", nm), 32'(cancel_o), 32'd0);
                return;
            end
            check($sformatf("%s/hdr%0d_cancel", nm, k), 32'(cancel_o), 32'd0);
        end

        for (int w = 0; w < nwords; w++) begin
            @(negedge clk);
            if (w == abort_word && !abort_rst) begin
                valid_i = 1'b0;
                #1;
                check($sformatf("%s/underrun_cancel", nm), 32'(cancel_o), 32'd1);
                check($sformatf("%s/underrun_err", nm), 32'(err_o), 32'd1);
                check($sformatf("%s/underrun_valid", nm), 32'(valid_o), 32'd0);
                @(negedge clk);
                #1;
                check($sformatf("%s/post_underrun_ready", nm), 32'(ready_o), 32'd0);
                check($sformatf("%s/post_underrun_cancel", nm), 32'(cancel_o), 32'd0);
                check($sformatf("%s/post_underrun_err", nm), 32'(err_o), 32'd0);
                return;
            end
            valid_i = 1'b1;
            data_i  = pay_word(base, w);
            len_i   = (w == nwords - 1 && nbytes[0]) ? 2'd1 : 2'd2;
            if (w == abort_word && abort_rst) nreset = 1'b0;
            #1;
            check($sformatf("%s/pay%0d_ready", nm, w), 32'(ready_o), 32'd1);
            check($sformatf("%s/pay%0d_valid", nm, w), 32'(valid_o), 32'd1);
            check($sformatf("%s/pay%0d_data", nm, w), 32'(data_o), 32'(pay_word(base, w)));
            check($sformatf("%s/pay%0d_len", nm, w), 32'(len_o),
                  (w == nwords - 1 && nbytes[0]) ? 32'd1 : 32'd2);
            check($sformatf("%s/pay%0d_err", nm, w), 32'(err_o), 32'd0);
            check($sformatf("%s/pay%0d_cancel", nm, w), 32'(cancel_o), 32'd0);
            if (w == abort_word && abort_rst) begin
                @(negedge clk);
                nreset  = 1'b1;
                valid_i = 1'b0;
                #1;
                check($sformatf("%s/post_rst_valid", nm), 32'(valid_o), 32'd0);
                check($sformatf("%s/post_rst_ready", nm), 32'(ready_o), 32'd0);
                check($sformatf("%s/post_rst_cancel", nm), 32'(cancel_o), 32'd0);
                return;
            end
        end

        if (!chain) begin
            @(negedge clk);
            valid_i = 1'b0;
            #1;
            check($sformatf("%s/end_ready", nm), 32'(ready_o), 32'd0);
            check($sformatf("%s/end_valid", nm), 32'(valid_o), 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset    = 1'b0;
        cancel_i  = 1'b0;
        valid_i   = 1'b0;
        data_i    = '0;
        len_i     = '0;
        pkt_len_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset/valid_o", 32'(valid_o), 32'd0);
        check("reset/ready_o", 32'(ready_o), 32'd0);
        check("reset/cancel_o", 32'(cancel_o), 32'd0);
        check("reset/err_o", 32'(err_o), 32'd0);
        check("reset/data_o", 32'(data_o), 32'd0);
        check("reset/len_o", 32'(len_o), 32'd0);
        @(negedge clk);
        nreset = 1'b1;

        // Back-to-back 8-byte packets: ids 0 and 1, checksums 0x9E3F and 0x9E3E.
        run_pkt("p8_id0", 16'd8, 16'h0000, 16'h9E3F, 8'h10, -1, -1, 1'b0, 1'b1);
        run_pkt("p8_id1", 16'd8, 16'h0001, 16'h9E3E, 8'h20, -1, -1, 1'b0, 1'b0);
        // 5 bytes: tot_len 25 and the last word carries 1 byte.
        run_pkt("p5_id2", 16'd5, 16'h0002, 16'h9E40, 8'h30, -1, -1, 1'b0, 1'b0);
        // 0 bytes: header only, ready_o stays low throughout.
        run_pkt("p0_id3", 16'd0, 16'h0003, 16'h9E44, 8'h40, -1, -1, 1'b0, 1'b0);
        // Underrun after 2 of 4 words.
        run_pkt("under_id4", 16'd8, 16'h0004, 16'h9E3B, 8'h50, -1, 2, 1'b0, 1'b0);
        // Cancel at hcnt 3, so id 5 is not consumed.
        run_pkt("cancel_id5", 16'd8, 16'h0005, 16'h9E3A, 8'h60, 3, -1, 1'b0, 1'b0);
        run_pkt("after_cancel_id5", 16'd8, 16'h0005, 16'h9E3A, 8'h70, -1, -1, 1'b0, 1'b0);

        // Oversize: 65516 bytes are consumed as 32758 words with no MAC output.
        @(negedge clk);
        valid_i   = 1'b1;
        data_i    = 16'hA5A5;
        len_i     = 2'd2;
        pkt_len_i = 16'd65516;
        #1;
        check("oversize/start_err", 32'(err_o), 32'd1);
        check("oversize/start_valid", 32'(valid_o), 32'd0);
        check("oversize/start_ready", 32'(ready_o), 32'd0);
        for (int w = 0; w < 32758; w++) begin
            @(negedge clk);
            data_i = 16'(w);
            #1;
            if (!ready_o) n_nordy++;
            if (valid_o) n_vld++;
            if (err_o) n_err++;
        end
        check("oversize/not_ready_cycles", 32'(n_nordy), 32'd0);
        check("oversize/valid_cycles", 32'(n_vld), 32'd0);
        check("oversize/err_cycles", 32'(n_err), 32'd0);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        check("oversize/end_ready", 32'(ready_o), 32'd0);
        check("oversize/end_err", 32'(err_o), 32'd0);

        // The oversize drop leaves id at 6. Force 0xFFFF to check the wrap.
        @(negedge clk);
        force dut.r_id_q = 16'hFFFF;
        @(negedge clk);
        release dut.r_id_q;
        run_pkt("id_ffff", 16'd0, 16'hFFFF, 16'h9E47, 8'h80, -1, -1, 1'b0, 1'b0);
        run_pkt("id_wrap0", 16'd0, 16'h0000, 16'h9E47, 8'h90, -1, -1, 1'b0, 1'b0);

        // Reset mid-DATA, then a clean 8-byte packet identical to the first.
        run_pkt("rst_id1", 16'd8, 16'h0001, 16'h9E3E, 8'hA0, -1, 1, 1'b1, 1'b0);
        run_pkt("after_rst_id0", 16'd8, 16'h0000, 16'h9E3F, 8'h10, -1, -1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
